// File: rtl/sweep_acq_pkg.sv
// Shared definitions for the DAC sweep acquisition controller: state encoding,
// output word constants and the SC-register bit-reverse helper.
package sweep_acq_pkg;

   localparam int unsigned MaxDacWidth = 10;
   localparam int unsigned TimeoutBit  = 24;

   localparam logic [15:0] HeaderWord  = 16'h5341;
   localparam logic [15:0] TailWord    = 16'hFF45;
   localparam logic [3:0]  ParamTag    = 4'hD;
   localparam logic [15:0] TimeoutWord = 16'hEE00;

   typedef enum logic [3:0] {
      StIdle,
      StHeaderOut,
      StParamOut,
      StLoadSc,
      StWaitLoad,
      StStartAcq,
      StWaitEvent,
      StReadWord,
      StOutWord,
      StNextEvent,
      StNextDac,
      StTailOut,
      StDone
   } sweepState_e;

   // The SC register expects LSB-first codes; reverse only the low `width` bits.
   function automatic logic [MaxDacWidth-1:0] bitReverse(input logic [MaxDacWidth-1:0] code,
                                                          input int unsigned width);
      logic [MaxDacWidth-1:0] rev;
      rev = {<<{code}};
      return rev >> (MaxDacWidth - width);
   endfunction

endpackage

// File: rtl/sweep_event_counter.sv
// Counts ParallelData_en word pulses while acquisition is enabled and flags each
// completed event until the sweep FSM consumes it.
module sweep_event_counter #(
   parameter int unsigned WORDS_PER_EVENT = 10
) (
   input  logic Clk,
   input  logic reset,
   input  logic enable,
   input  logic wordStrobe,
   input  logic consume,
   output logic eventDone
);

   localparam int unsigned CntW = $clog2(WORDS_PER_EVENT + 1);

   logic [CntW-1:0] wordCntQ;
   logic            eventDoneQ;

   always_ff @(posedge Clk) begin
      if (reset || !enable) begin
         wordCntQ   <= '0;
         eventDoneQ <= 1'b0;
      end else begin
         if (consume) eventDoneQ <= 1'b0;
         if (wordStrobe) begin
            if (wordCntQ == CntW'(WORDS_PER_EVENT - 1)) begin
               wordCntQ   <= '0;
               eventDoneQ <= 1'b1;
            end else begin
               wordCntQ <= wordCntQ + CntW'(1);
            end
         end
      end
   end

   assign eventDone = eventDoneQ;

endmodule

// File: rtl/multi_dac_sweep_control.sv
// Sweeps one Microroc DAC across a range, loads SC, acquires events and streams
// them framed by header/tail words. Define SWEEP_EVENT_TIMEOUT_EN for event timeout.
module multi_dac_sweep_control
   import sweep_acq_pkg::*;
#(
   parameter int unsigned DAC_WIDTH       = 10,
   parameter int unsigned NUM_DAC         = 3,
   parameter int unsigned WORDS_PER_EVENT = 10,
   parameter int unsigned LOAD_DELAY      = 40000
) (
   input  logic                         Clk,
   input  logic                         reset,
   input  logic                         SweepStart,
   input  logic                         SweepAbort,
   input  logic [DAC_WIDTH-1:0]         StartDAC,
   input  logic [DAC_WIDTH-1:0]         EndDAC,
   input  logic [DAC_WIDTH-1:0]         StepDAC,
   input  logic [1:0]                   DACSelect,
   input  logic [NUM_DAC*DAC_WIDTH-1:0] DefaultDAC,
   input  logic [15:0]                  MaxPackageNumber,
   input  logic                         ParallelData_en,
   output logic [NUM_DAC*DAC_WIDTH-1:0] OutDAC,
   output logic                         LoadSCParameter,
   input  logic                         MicrorocConfigDone,
   output logic                         SingleACQStart,
   input  logic [15:0]                  SweepACQFifoData,
   output logic                         SweepACQFifoData_rden,
   output logic [15:0]                  SweepACQData,
   output logic                         SweepACQData_en,
   output logic                         ACQDone,
   output logic                         Busy
);

   localparam int unsigned LoadCntW = $clog2(LOAD_DELAY + 1) + 1;

   sweepState_e                  stateQ, stateD;
   logic                         startQ;
   logic [DAC_WIDTH-1:0]         startDacQ, startDacD, endDacQ, endDacD, stepDacQ, stepDacD;
   logic [DAC_WIDTH-1:0]         curCodeQ, curCodeD;
   logic [1:0]                   dacSelQ, dacSelD;
   logic [NUM_DAC*DAC_WIDTH-1:0] defaultDacQ, defaultDacD, outDacQ, outDacD;
   logic [15:0]                  maxPkgQ, maxPkgD, eventIdxQ, eventIdxD;
   logic [7:0]                   wordIdxQ, wordIdxD;
   logic                         acqStartQ, acqStartD;
   logic [15:0]                  dataQ, dataD;
   logic                         dataEnQ, dataEnD;
   logic                         loadSeenQ, loadSeenD;
   logic [LoadCntW-1:0]          loadCntQ, loadCntD;
   logic [DAC_WIDTH:0]           nextCode;
   logic [MaxDacWidth-1:0]       revCode;
   logic                         eventDone, eventConsume;
`ifdef SWEEP_EVENT_TIMEOUT_EN
   logic [TimeoutBit:0]          timeoutCntQ, timeoutCntD;
`endif

   sweep_event_counter #(
      .WORDS_PER_EVENT(WORDS_PER_EVENT)
   ) uEventCounter (
      .Clk       (Clk),
      .reset     (reset),
      .enable    (acqStartQ),
      .wordStrobe(ParallelData_en),
      .consume   (eventConsume),
      .eventDone (eventDone)
   );

   always_ff @(posedge Clk) begin
      if (reset) begin
         stateQ      <= StIdle;
         startQ      <= 1'b0;
         startDacQ   <= '0;
         endDacQ     <= '0;
         stepDacQ    <= '0;
         curCodeQ    <= '0;
         dacSelQ     <= '0;
         defaultDacQ <= '0;
         outDacQ     <= '0;
         maxPkgQ     <= '0;
         eventIdxQ   <= '0;
         wordIdxQ    <= '0;
         acqStartQ   <= 1'b0;
         dataQ       <= '0;
         dataEnQ     <= 1'b0;
         loadSeenQ   <= 1'b0;
         loadCntQ    <= '0;
`ifdef SWEEP_EVENT_TIMEOUT_EN
         timeoutCntQ <= '0;
`endif
      end else begin
         stateQ      <= stateD;
         startQ      <= SweepStart;
         startDacQ   <= startDacD;
         endDacQ     <= endDacD;
         stepDacQ    <= stepDacD;
         curCodeQ    <= curCodeD;
         dacSelQ     <= dacSelD;
         defaultDacQ <= defaultDacD;
         outDacQ     <= outDacD;
         maxPkgQ     <= maxPkgD;
         eventIdxQ   <= eventIdxD;
         wordIdxQ    <= wordIdxD;
         acqStartQ   <= acqStartD;
         dataQ       <= dataD;
         dataEnQ     <= dataEnD;
         loadSeenQ   <= loadSeenD;
         loadCntQ    <= loadCntD;
`ifdef SWEEP_EVENT_TIMEOUT_EN
         timeoutCntQ <= timeoutCntD;
`endif
      end
   end

   always_comb begin
      stateD       = stateQ;
      startDacD    = startDacQ;
      endDacD      = endDacQ;
      stepDacD     = stepDacQ;
      curCodeD     = curCodeQ;
      dacSelD      = dacSelQ;
      defaultDacD  = defaultDacQ;
      outDacD      = outDacQ;
      maxPkgD      = maxPkgQ;
      eventIdxD    = eventIdxQ;
      wordIdxD     = wordIdxQ;
      acqStartD    = acqStartQ;
      dataD        = dataQ;
      dataEnD      = 1'b0;
      loadSeenD    = loadSeenQ;
      loadCntD     = loadCntQ;
      eventConsume = 1'b0;
      revCode      = '0;
      nextCode     = {1'b0, curCodeQ} + {1'b0, stepDacQ};
`ifdef SWEEP_EVENT_TIMEOUT_EN
      timeoutCntD  = '0;
`endif

      unique case (stateQ)
         StIdle: begin
            if (SweepStart && !startQ) begin
               startDacD   = StartDAC;
               endDacD     = EndDAC;
               stepDacD    = (StepDAC == '0) ? DAC_WIDTH'(1) : StepDAC;
               curCodeD    = StartDAC;
               dacSelD     = DACSelect;
               defaultDacD = DefaultDAC;
               maxPkgD     = (MaxPackageNumber == '0) ? 16'd1 : MaxPackageNumber;
               stateD      = StHeaderOut;
            end
         end
         // Emitting states hold off while the previous strobe is high to keep a gap.
         StHeaderOut: begin
            if (!dataEnQ) begin
               dataD   = HeaderWord;
               dataEnD = 1'b1;
               stateD  = (startDacQ > endDacQ) ? StTailOut : StParamOut;
            end
         end
         StParamOut: begin
            if (!dataEnQ) begin
               dataD   = {ParamTag, dacSelQ, MaxDacWidth'(curCodeQ)};
               dataEnD = 1'b1;
               for (int unsigned i = 0; i < NUM_DAC; i++) begin
                  if (dacSelQ == 2'(i)) begin
                     revCode = bitReverse(MaxDacWidth'(curCodeQ), DAC_WIDTH);
                  end else begin
                     revCode = bitReverse(MaxDacWidth'(defaultDacQ[i*DAC_WIDTH +: DAC_WIDTH]),
                                          DAC_WIDTH);
                  end
                  outDacD[i*DAC_WIDTH +: DAC_WIDTH] = revCode[DAC_WIDTH-1:0];
               end
               stateD = StLoadSc;
            end
         end
         StLoadSc: begin
            loadSeenD = MicrorocConfigDone;
            loadCntD  = '0;
            stateD    = StWaitLoad;
         end
         StWaitLoad: begin
            if (!loadSeenQ) begin
               loadSeenD = MicrorocConfigDone;
            end else if (loadCntQ >= LoadCntW'(LOAD_DELAY)) begin
               stateD = StStartAcq;
            end else begin
               loadCntD = loadCntQ + LoadCntW'(1);
            end
         end
         StStartAcq: begin
            acqStartD = 1'b1;
            eventIdxD = '0;
            stateD    = StWaitEvent;
         end
         StWaitEvent: begin
            if (eventDone) begin
               eventConsume = 1'b1;
               wordIdxD     = '0;
               stateD       = StReadWord;
            end
`ifdef SWEEP_EVENT_TIMEOUT_EN
            else if (timeoutCntQ[TimeoutBit] && !dataEnQ) begin
               dataD   = TimeoutWord | 16'(dacSelQ);
               dataEnD = 1'b1;
               stateD  = StNextDac;
            end else begin
               timeoutCntD = timeoutCntQ + (TimeoutBit + 1)'(1);
            end
`endif
         end
         StReadWord: stateD = StOutWord;
         StOutWord: begin
            dataD   = SweepACQFifoData;
            dataEnD = 1'b1;
            if (wordIdxQ == 8'(WORDS_PER_EVENT - 1)) begin
               stateD = StNextEvent;
            end else begin
               wordIdxD = wordIdxQ + 8'd1;
               stateD   = StReadWord;
            end
         end
         StNextEvent: begin
            if (({1'b0, eventIdxQ} + 17'd1) >= {1'b0, maxPkgQ}) begin
               stateD = StNextDac;
            end else begin
               eventIdxD = eventIdxQ + 16'd1;
               stateD    = StWaitEvent;
            end
         end
         StNextDac: begin
            acqStartD = 1'b0;
            if (!nextCode[DAC_WIDTH] && (nextCode[DAC_WIDTH-1:0] <= endDacQ)) begin
               curCodeD = nextCode[DAC_WIDTH-1:0];
               stateD   = StParamOut;
            end else begin
               stateD = StTailOut;
            end
         end
         StTailOut: begin
            if (!dataEnQ) begin
               dataD   = TailWord;
               dataEnD = 1'b1;
               stateD  = StDone;
            end
         end
         StDone:  stateD = StIdle;
         default: stateD = StIdle;
      endcase

      if (SweepAbort && !(stateQ inside {StIdle, StTailOut, StDone})) begin
         acqStartD = 1'b0;
         stateD    = StTailOut;
      end
   end

   assign OutDAC                = outDacQ;
   assign LoadSCParameter       = (stateQ == StLoadSc);
   assign SingleACQStart        = acqStartQ;
   assign SweepACQFifoData_rden = (stateQ == StReadWord);
   assign SweepACQData          = dataQ;
   assign SweepACQData_en       = dataEnQ;
   assign ACQDone               = (stateQ == StDone);
   assign Busy                  = (stateQ != StIdle);

endmodule
